bp_lce_resp_arb: RTL and testbench

Parametrised, registered arbiter merging `num_src_p` LCE-to-CCE response sources onto one `lce_resp` channel. It replaces the combinational two-way response mux in the I/D-cache LCE tops, which select between the lce_req transfer response and the lce_cmd sync/inv ack. Over that mux it adds:
- an output register that holds its payload stable;
- selectable fixed-priority or round-robin arbitration;
- an optional starvation guard.

---
 rtl/bp_lce_resp_arb.sv | 143 ++++++++++++++
 tb/tb_bp_lce_resp_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_lce_resp_arb.sv
// bp_lce_resp_arb: registered arbiter merging num_src_p LCE-to-CCE response
// sources onto a single lce_resp channel. Fixed-priority (lowest index wins)
// or round-robin selection through arb_rr_p.
// Optional starvation guard: define BP_LCE_RESP_ARB_STARVE_GUARD_EN to build
// per-source wait counters whose starved sources preempt normal arbitration.
module bp_lce_resp_arb #(
  parameter int unsigned num_src_p      = 2,
  parameter int unsigned resp_width_p   = 8,
  parameter bit          arb_rr_p       = 1'b0,
  parameter int unsigned starve_limit_p = 15,
  localparam int unsigned grant_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_src_p*resp_width_p-1:0]     src_resp_i,
  input  logic [num_src_p-1:0]                  src_v_i,
  output logic [num_src_p-1:0]                  src_yumi_o,
  output logic [resp_width_p-1:0]               lce_resp_o,
  output logic                                  lce_resp_v_o,
  input  logic                                  lce_resp_ready_i,
  output logic [grant_width_lp-1:0]             grant_id_o
);

  logic                      r_full;
  logic [resp_width_p-1:0]   r_data;
  logic [grant_width_lp-1:0] r_grant_id;
  logic [grant_width_lp-1:0] r_last_grant;

  logic                      w_load;
  logic                      w_any;
  logic                      w_grant;
  logic [num_src_p-1:0]      w_starved;
  logic                      w_st_found;
  logic [grant_width_lp-1:0] w_st_idx;
  logic                      w_fp_found;
  logic [grant_width_lp-1:0] w_fp_idx;
  logic                      w_hi_found;
  logic [grant_width_lp-1:0] w_hi_idx;
  logic [grant_width_lp-1:0] w_winner;
  logic [resp_width_p-1:0]   w_sel;

`ifdef BP_LCE_RESP_ARB_STARVE_GUARD_EN
  localparam int unsigned cnt_width_lp = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;

  logic [cnt_width_lp-1:0] r_wait_cnt [num_src_p];

  // Per-source saturating wait counters; cleared on grant or when valid drops
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_src_p; i++) r_wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < num_src_p; i++) begin
        if (!src_v_i[i] || src_yumi_o[i])
          r_wait_cnt[i] <= '0;
        else if (r_wait_cnt[i] != cnt_width_lp'(starve_limit_p))
          r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
      end
    end
  end

  // A valid source whose counter reached the limit is starved
  always_comb begin
    for (int i = 0; i < num_src_p; i++)
      w_starved[i] = src_v_i[i] && (r_wait_cnt[i] == cnt_width_lp'(starve_limit_p));
  end
`else
  logic w_unused_starve_limit;

  assign w_unused_starve_limit = (starve_limit_p == 0);
  assign w_starved             = '0;
`endif

  assign w_load  = !r_full || lce_resp_ready_i;
  assign w_any   = |src_v_i;
  assign w_grant = reset_n_i && w_load && w_any;

  // Candidate searches: starved lowest, plain lowest, lowest above last grant
  always_comb begin
    w_st_found = 1'b0;
    w_st_idx   = '0;
    w_fp_found = 1'b0;
    w_fp_idx   = '0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    for (int i = 0; i < num_src_p; i++) begin
      if (w_starved[i] && !w_st_found) begin
        w_st_found = 1'b1;
        w_st_idx   = grant_width_lp'(i);
      end
      if (src_v_i[i] && !w_fp_found) begin
        w_fp_found = 1'b1;
        w_fp_idx   = grant_width_lp'(i);
      end
      if (src_v_i[i] && !w_hi_found && (i > int'(r_last_grant))) begin
        w_hi_found = 1'b1;
        w_hi_idx   = grant_width_lp'(i);
      end
    end
  end

  // Winner: starved first, then round robin (wrap to lowest) or fixed priority
  always_comb begin
    w_winner = w_fp_idx;
    if (w_st_found)
      w_winner = w_st_idx;
    else if (arb_rr_p && w_hi_found)
      w_winner = w_hi_idx;
  end

  // One-hot consume and payload select for the winner
  always_comb begin
    src_yumi_o = '0;
    w_sel      = '0;
    for (int i = 0; i < num_src_p; i++) begin
      if (w_winner == grant_width_lp'(i)) begin
        src_yumi_o[i] = w_grant;
        w_sel         = src_resp_i[i*resp_width_p +: resp_width_p];
      end
    end
  end

  // Output register: load on empty or drain, hold under backpressure
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_full       <= 1'b0;
      r_data       <= '0;
      r_grant_id   <= '0;
      r_last_grant <= grant_width_lp'(num_src_p - 1);
    end else if (w_load) begin
      r_full <= w_any;
      if (w_any) begin
        r_data       <= w_sel;
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
      end
    end
  end

  assign lce_resp_o   = r_data;
  assign lce_resp_v_o = r_full;
  assign grant_id_o   = r_grant_id;

endmodule

// File: tb/tb_bp_lce_resp_arb.sv
// Bench for bp_lce_resp_arb: a 2-source fixed-priority instance and a
// 4-source round-robin instance, checked against a transaction-level model.
module tb_bp_lce_resp_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-instance stimulus (index 0: instance A, index 1: instance B)
  logic [3:0] v_in [2];
  logic [7:0] d_in [2][4];
  logic       rdy  [2];

  int n_src [2] = '{2, 4};
  bit rr    [2] = '{1'b0, 1'b1};
  int lim   [2] = '{3, 3};

  // Reference model state
  bit         m_full [2];
  logic [7:0] m_data [2];
  int         m_gid  [2];
  int         m_last [2];
  int         m_wait [2][4];

  logic [1:0]  va, ya;
  logic [15:0] ra;
  logic [7:0]  oa;
  logic        ova;
  logic        ga;
  logic [3:0]  vb, yb;
  logic [31:0] rb;
  logic [7:0]  ob;
  logic        ovb;
  logic [1:0]  gb;
  logic        rdy_a, rdy_b;

  always_comb begin
    va    = v_in[0][1:0];
    vb    = v_in[1];
    ra    = {d_in[0][1], d_in[0][0]};
    rb    = {d_in[1][3], d_in[1][2], d_in[1][1], d_in[1][0]};
    rdy_a = rdy[0];
    rdy_b = rdy[1];
  end

  bp_lce_resp_arb #(.num_src_p(2), .resp_width_p(8), .arb_rr_p(1'b0), .starve_limit_p(3)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .src_resp_i(ra), .src_v_i(va), .src_yumi_o(ya),
    .lce_resp_o(oa), .lce_resp_v_o(ova), .lce_resp_ready_i(rdy_a), .grant_id_o(ga));

  bp_lce_resp_arb #(.num_src_p(4), .resp_width_p(8), .arb_rr_p(1'b1), .starve_limit_p(3)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .src_resp_i(rb), .src_v_i(vb), .src_yumi_o(yb),
    .lce_resp_o(ob), .lce_resp_v_o(ovb), .lce_resp_ready_i(rdy_b), .grant_id_o(gb));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(int d);
    m_full[d] = 1'b0;
    m_data[d] = 8'h00;
    m_gid[d]  = 0;
    m_last[d] = n_src[d] - 1;
    for (int i = 0; i < 4; i++) m_wait[d][i] = 0;
  endtask

  // Winner the model expects this cycle, or -1 when nothing is granted
  function automatic int pick(int d);
    int  w     = -1;
    bit  found = 1'b0;
    if (m_full[d] && !rdy[d]) return -1;
`ifdef BP_LCE_RESP_ARB_STARVE_GUARD_EN
    for (int i = 0; i < n_src[d]; i++)
      if (!found && v_in[d][i] && m_wait[d][i] >= lim[d]) begin found = 1'b1; w = i; end
`endif
    for (int k = 0; k < n_src[d]; k++) begin
      int c;
      c = rr[d] ? (m_last[d] + 1 + k) % n_src[d] : k;
      if (!found && v_in[d][c]) begin found = 1'b1; w = c; end
    end
    return w;
  endfunction

  task automatic model_edge(int d, int w);
    bit load;
    load = !m_full[d] || rdy[d];
    for (int i = 0; i < n_src[d]; i++) begin
      if (!v_in[d][i] || i == w) m_wait[d][i] = 0;
      else if (m_wait[d][i] < lim[d]) m_wait[d][i]++;
    end
    if (load) begin
      if (w >= 0) begin
        m_full[d] = 1'b1;
        m_data[d] = d_in[d][w];
        m_gid[d]  = w;
        m_last[d] = w;
      end else begin
        m_full[d] = 1'b0;
      end
    end
  endtask

  // One cycle: called just after a negedge with inputs applied
  task automatic tick();
    int w [2];
    #1;
    for (int d = 0; d < 2; d++) w[d] = rst_n ? pick(d) : -1;
    chk("yumi_a", 32'(ya), (w[0] >= 0) ? (32'd1 << w[0]) : 32'd0);
    chk("yumi_b", 32'(yb), (w[1] >= 0) ? (32'd1 << w[1]) : 32'd0);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      else model_edge(d, w[d]);
    end
    #1;
    chk("valid_a", 32'(ova), 32'(m_full[0]));
    chk("valid_b", 32'(ovb), 32'(m_full[1]));
    if (m_full[0]) begin
      chk("data_a", 32'(oa), 32'(m_data[0]));
      chk("gid_a", 32'(ga), 32'(m_gid[0]));
    end
    if (m_full[1]) begin
      chk("data_b", 32'(ob), 32'(m_data[1]));
      chk("gid_b", 32'(gb), 32'(m_gid[1]));
    end
    @(negedge clk);
  endtask

  initial begin
    int cnt1;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v_in[d] = 4'b0000;
      rdy[d]  = 1'b1;
      for (int i = 0; i < 4; i++) d_in[d][i] = 8'(i + 8'h30);
      model_reset(d);
    end
    @(negedge clk);

    // Reset held with sources valid: nothing consumed, outputs zero
    v_in[0] = 4'b0011;
    v_in[1] = 4'b1111;
    repeat (3) tick();
    chk("rst_data_a", 32'(oa), 32'h0);
    chk("rst_gid_b", 32'(gb), 32'h0);

    rst_n   = 1'b1;
    v_in[0] = 4'b0000;
    v_in[1] = 4'b0000;
    tick();

    // Basic pass: src1 alone with 0xA5
    v_in[0]     = 4'b0010;
    d_in[0][1]  = 8'hA5;
    #1 chk("basic_yumi", 32'(ya), 32'h2);
    tick();
    chk("basic_data", 32'(oa), 32'hA5);
    chk("basic_gid", 32'(ga), 32'h1);
    chk("basic_v", 32'(ova), 32'h1);

    // Backpressure: hold 0x11 while src0 offers 0x22
    v_in[0]    = 4'b0001;
    d_in[0][0] = 8'h11;
    tick();
    d_in[0][0] = 8'h22;
    rdy[0]     = 1'b0;
    repeat (5) tick();
    chk("bp_hold", 32'(oa), 32'h11);
    rdy[0] = 1'b1;
    tick();
    chk("bp_release", 32'(oa), 32'h22);
    chk("bp_no_bubble", 32'(ova), 32'h1);
    v_in[0] = 4'b0000;
    tick();

    // Fixed priority, both sources valid for 20 cycles
    v_in[0]    = 4'b0011;
    d_in[0][0] = 8'h40;
    d_in[0][1] = 8'h41;
    cnt1 = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ga == 1'b1) cnt1++;
    end
`ifdef BP_LCE_RESP_ARB_STARVE_GUARD_EN
    chk("fp_src1_grants", 32'(cnt1), 32'd5);
`else
    chk("fp_src1_grants", 32'(cnt1), 32'd0);
`endif
    v_in[0] = 4'b0000;
    tick();

    // Round robin on B: first grant after reset is 0, order 0,1,2,3,0
    v_in[1] = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_order", 32'(gb), 32'(k % 4));
    end
    v_in[1] = 4'b0000;
    tick();

    // Randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        v_in[d] = 4'($urandom) & ((d == 0) ? 4'b0011 : 4'b1111);
        rdy[d]  = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) d_in[d][i] = 8'($urandom);
      end
      tick();
    end

    // Reset mid-transfer while FULL under backpressure
    v_in[0] = 4'b0011;
    v_in[1] = 4'b1111;
    rdy[0]  = 1'b0;
    rdy[1]  = 1'b0;
    repeat (2) tick();
    chk("pre_rst_full_a", 32'(ova), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop_a", 32'(ova), 32'h0);
    chk("async_drop_b", 32'(ovb), 32'h0);
    chk("async_yumi_a", 32'(ya), 32'h0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    repeat (2) tick();
    rst_n   = 1'b1;
    v_in[0] = 4'b0000;
    v_in[1] = 4'b0000;
    tick();
    chk("post_rst_empty_a", 32'(ova), 32'h0);
    v_in[1] = 4'b0100;
    tick();
    v_in[1] = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
